// File: rtl/stopwatch_core_pkg.sv
// Shared stopwatch types: FSM state encoding, field width and the field limit.
package stopwatch_core_pkg;

   localparam int unsigned FIELD_W = 8;

   typedef logic [FIELD_W-1:0] field_t;

   localparam field_t MAX_FIELD = field_t'(59);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StAdj
   } sw_state_e;

   // Saturating compare keeps the field inside 0..MAX_FIELD even from a corrupt value.
   function automatic field_t inc_wrap(input field_t f);
      return (f >= MAX_FIELD) ? '0 : f + field_t'(1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and registered rising-edge pulse
// for one raw pushbutton or switch.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q, samp_q;
   logic [1:0]      vld_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            armed_q, armed_d;
   logic            prev_q, rise_q;
   logic            pending, restart, hit;

   // Until a stable low has been seen the input is not armed: a button held through
   // reset debounces high silently and only pulses after a release and a new press.
   always_comb begin
      pending = (sync2_q != level_q) | (~armed_q & ~sync2_q & vld_q[1]);
      restart = ~armed_q & (sync2_q != samp_q);
      hit     = restart ? (DEBOUNCE_CYCLES == 1) : (cnt_q == CntLast);
      level_d = level_q;
      armed_d = armed_q;
      cnt_d   = '0;
      if (pending) begin
         if (hit) begin
            level_d = sync2_q;
            armed_d = armed_q | ~sync2_q;
         end else if (restart) begin
            cnt_d = CntW'(1);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         samp_q  <= 1'b0;
         vld_q   <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         armed_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         samp_q  <= sync2_q;
         vld_q   <= {vld_q[0], 1'b1};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         armed_q <= armed_d;
         prev_q  <= level_q;
         rise_q  <= level_q & ~prev_q & armed_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch: debounced controls, IDLE/RUN/PAUSE FSM and wrapping counters.
// Define STOPWATCH_ADJUST_EN to build the ADJ state driven by sw_adj, sw_sel and tick_2hz.
module stopwatch_core
   import stopwatch_core_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_1hz,
   input  logic               tick_2hz,
   input  logic               btn_pause,
   input  logic               btn_clear,
   input  logic               sw_adj,
   input  logic               sw_sel,
   output logic [FIELD_W-1:0] minutes,
   output logic [FIELD_W-1:0] seconds,
   output logic               running
);

   sw_state_e state_q;
   field_t    min_q, sec_q;
   logic      run_q;
   logic      press_pause, press_clear;
   logic      pause_lvl, clear_lvl;
   logic      unused_lvl;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_pause),
      .level_o(pause_lvl),
      .rise_o (press_pause)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_clear),
      .level_o(clear_lvl),
      .rise_o (press_clear)
   );

   assign unused_lvl = pause_lvl ^ clear_lvl;

`ifdef STOPWATCH_ADJUST_EN
   logic adj_lvl, sel_lvl, adj_rise, sel_rise;
   logic unused_rise;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adj (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_adj),
      .level_o(adj_lvl),
      .rise_o (adj_rise)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (sw_sel),
      .level_o(sel_lvl),
      .rise_o (sel_rise)
   );

   assign unused_rise = adj_rise ^ sel_rise;
`else
   logic unused_adj;
   assign unused_adj = tick_2hz ^ sw_adj ^ sw_sel;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         min_q   <= '0;
         sec_q   <= '0;
         run_q   <= 1'b0;
      end else if (press_clear) begin
         state_q <= StIdle;
         min_q   <= '0;
         sec_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StPause: begin
               if (press_pause) begin
                  state_q <= StRun;
                  run_q   <= 1'b1;
               end
`ifdef STOPWATCH_ADJUST_EN
               else if (adj_lvl) begin
                  state_q <= StAdj;
               end
`endif
            end
            StRun: begin
               // The tick is applied even when a pause press lands in the same cycle.
               if (tick_1hz) begin
                  sec_q <= inc_wrap(sec_q);
                  if (sec_q == MAX_FIELD) min_q <= inc_wrap(min_q);
               end
               if (press_pause) begin
                  state_q <= StPause;
                  run_q   <= 1'b0;
               end
            end
`ifdef STOPWATCH_ADJUST_EN
            StAdj: begin
               if (tick_2hz) begin
                  if (sel_lvl) sec_q <= inc_wrap(sec_q);
                  else         min_q <= inc_wrap(min_q);
               end
               if (!adj_lvl) state_q <= StPause;
            end
`endif
            default: begin
               state_q <= StIdle;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign minutes = min_q;
   assign seconds = sec_q;
   assign running = run_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core with DEBOUNCE_CYCLES=4; follows STOPWATCH_ADJUST_EN.
module tb_stopwatch_core;

   localparam int DC = 4;
   localparam int IDLE = 0, RUN = 1, PAUSE = 2, ADJ = 3;
`ifdef STOPWATCH_ADJUST_EN
   localparam bit AdjEn = 1'b1;
`else
   localparam bit AdjEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
   logic       btn_pause = 1'b0, btn_clear = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
   logic [7:0] minutes, seconds;
   logic       running;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   // Model: raw sample history per input (0 pause, 1 clear, 2 adj, 3 sel) and time fields.
   int m_state, m_min, m_sec, m_n;
   bit m_hist[4][DC+2];
   bit m_lvl[4], m_armed[4], m_rise[4], m_pulse[4];

   stopwatch_core #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_1hz (tick_1hz),
      .tick_2hz (tick_2hz),
      .btn_pause(btn_pause),
      .btn_clear(btn_clear),
      .sw_adj   (sw_adj),
      .sw_sel   (sw_sel),
      .minutes  (minutes),
      .seconds  (seconds),
      .running  (running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = IDLE;
      m_min   = 0;
      m_sec   = 0;
      m_n     = 0;
      for (int b = 0; b < 4; b++) begin
         m_lvl[b]   = 1'b0;
         m_armed[b] = 1'b0;
         m_rise[b]  = 1'b0;
         m_pulse[b] = 1'b0;
         for (int i = 0; i < DC + 2; i++) m_hist[b][i] = 1'b0;
      end
   endtask

   // A level is accepted once the synchronized input has held one value for DC cycles;
   // a rise becomes a press visible to the FSM two cycles later.
   task automatic model_edge();
      bit raw[4];
      bit all1, all0;
      int tot;
      raw[0] = btn_pause;
      raw[1] = btn_clear;
      raw[2] = sw_adj;
      raw[3] = sw_sel;
      if (m_pulse[1]) begin
         m_state = IDLE;
         m_min   = 0;
         m_sec   = 0;
      end else begin
         case (m_state)
            IDLE, PAUSE: begin
               if (m_pulse[0]) m_state = RUN;
               else if (AdjEn && m_lvl[2]) m_state = ADJ;
            end
            RUN: begin
               if (tick_1hz) begin
                  tot   = (m_min * 60 + m_sec + 1) % 3600;
                  m_min = tot / 60;
                  m_sec = tot % 60;
               end
               if (m_pulse[0]) m_state = PAUSE;
            end
            default: begin
               if (tick_2hz) begin
                  if (m_lvl[3]) m_sec = (m_sec + 1) % 60;
                  else          m_min = (m_min + 1) % 60;
               end
               if (!m_lvl[2]) m_state = PAUSE;
            end
         endcase
      end
      for (int b = 0; b < 4; b++) begin
         m_pulse[b] = m_rise[b];
         m_rise[b]  = 1'b0;
      end
      m_n++;
      for (int b = 0; b < 4; b++) begin
         for (int i = DC + 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
         m_hist[b][0] = raw[b];
      end
      if (m_n >= DC + 2) begin
         for (int b = 0; b < 4; b++) begin
            all1 = 1'b1;
            all0 = 1'b1;
            for (int i = 2; i <= DC + 1; i++) begin
               if (m_hist[b][i]) all0 = 1'b0;
               else              all1 = 1'b0;
            end
            if (all1 && !m_lvl[b]) begin
               m_lvl[b]  = 1'b1;
               m_rise[b] = m_armed[b];
            end
            if (all0) begin
               m_lvl[b]   = 1'b0;
               m_armed[b] = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
   endtask

   task automatic step_n(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic press(input int which);
      if (which == 0) btn_pause = 1'b1;
      else            btn_clear = 1'b1;
      step_n(10);
      btn_pause = 1'b0;
      btn_clear = 1'b0;
      step_n(10);
   endtask

   always @(negedge clk) begin
      if (chk_on && rst_n) begin
         chk("cyc_minutes", int'(minutes), m_min);
         chk("cyc_seconds", int'(seconds), m_sec);
         chk("cyc_running", int'(running), (m_state == RUN) ? 1 : 0);
      end
   end

   initial begin
      model_reset();
      #3;
      chk("rst_minutes", int'(minutes), 0);
      chk("rst_seconds", int'(seconds), 0);
      chk("rst_running", int'(running), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_on = 1'b1;
      step_n(12);

      // Press latency: pulse 7 cycles after the raw rise, RUN on the next cycle.
      btn_pause = 1'b1;
      step_n(7);
      chk("press_lat_before", int'(running), 0);
      step();
      chk("press_lat_run", int'(running), 1);
      step_n(2);
      btn_pause = 1'b0;
      step_n(10);

      tick_1hz = 1'b1;
      step_n(58);
      chk("run_00_58", int'(seconds), 58);
      step();
      chk("run_00_59", int'(seconds), 59);
      chk("run_00_59_min", int'(minutes), 0);
      step();
      chk("carry_sec", int'(seconds), 0);
      chk("carry_min", int'(minutes), 1);
      step_n(3539);
      chk("run_59_59_min", int'(minutes), 59);
      chk("run_59_59_sec", int'(seconds), 59);
      step();
      tick_1hz = 1'b0;
      chk("wrap_min", int'(minutes), 0);
      chk("wrap_sec", int'(seconds), 0);
      chk("wrap_running", int'(running), 1);

      // Bouncy press must toggle RUN->PAUSE exactly once.
      btn_pause = 1'b1;
      step_n(2);
      btn_pause = 1'b0;
      step_n(2);
      btn_pause = 1'b1;
      step_n(12);
      btn_pause = 1'b0;
      step_n(10);
      chk("bounce_one_press", int'(running), 0);

      press(0);
      chk("resume_run", int'(running), 1);
      tick_1hz = 1'b1;
      step_n(187);
      tick_1hz = 1'b0;
      chk("run_03_07_min", int'(minutes), 3);
      chk("run_03_07_sec", int'(seconds), 7);

      // Tick and pause press in the same cycle.
      btn_pause = 1'b1;
      step_n(7);
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      chk("tick_pause_sec", int'(seconds), 8);
      chk("tick_pause_running", int'(running), 0);
      step_n(2);
      btn_pause = 1'b0;
      step_n(10);
      tick_1hz = 1'b1;
      step_n(5);
      tick_1hz = 1'b0;
      chk("paused_tick_ignored", int'(seconds), 8);

      // Adjust mode (ignored entirely when the feature is not built).
      sw_adj = 1'b1;
      sw_sel = 1'b1;
      step_n(10);
      tick_2hz = 1'b1;
      step_n(51);
      tick_2hz = 1'b0;
      chk("adj_sec_59", int'(seconds), AdjEn ? 59 : 8);
      tick_2hz = 1'b1;
      step();
      tick_2hz = 1'b0;
      chk("adj_no_carry_sec", int'(seconds), AdjEn ? 0 : 8);
      chk("adj_no_carry_min", int'(minutes), 3);
      sw_sel = 1'b0;
      step_n(10);
      tick_2hz = 1'b1;
      step();
      tick_2hz = 1'b0;
      chk("adj_min", int'(minutes), AdjEn ? 4 : 3);
      tick_1hz = 1'b1;
      step_n(3);
      tick_1hz = 1'b0;
      sw_adj = 1'b0;
      step_n(10);
      chk("adj_exit_running", int'(running), 0);

      press(0);
      chk("run_again", int'(running), 1);
      tick_1hz = 1'b1;
      tick_2hz = 1'b1;
      step_n(AdjEn ? 514 : 566);
      tick_1hz = 1'b0;
      tick_2hz = 1'b0;
      chk("run_12_34_min", int'(minutes), 12);
      chk("run_12_34_sec", int'(seconds), 34);

      // Asynchronous reset mid-RUN with the pause button held through it.
      btn_pause = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_min", int'(minutes), 0);
      chk("async_rst_sec", int'(seconds), 0);
      chk("async_rst_running", int'(running), 0);
      step_n(3);
      rst_n = 1'b1;
      step_n(20);
      chk("held_no_press", int'(running), 0);
      btn_pause = 1'b0;
      step_n(10);
      press(0);
      chk("repress_run", int'(running), 1);

      tick_1hz = 1'b1;
      step_n(5);
      tick_1hz = 1'b0;
      press(0);
      chk("pause_at_5", int'(seconds), 5);
      chk("pause_at_5_running", int'(running), 0);

      // Clear and pause pressed together: clear wins.
      btn_pause = 1'b1;
      btn_clear = 1'b1;
      step_n(10);
      btn_pause = 1'b0;
      btn_clear = 1'b0;
      step_n(10);
      chk("clear_prio_running", int'(running), 0);
      chk("clear_prio_sec", int'(seconds), 0);
      chk("clear_prio_min", int'(minutes), 0);
      tick_1hz = 1'b1;
      step_n(4);
      tick_1hz = 1'b0;
      chk("idle_tick_ignored", int'(seconds), 0);
      press(0);
      chk("idle_to_run", int'(running), 1);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000; the number of consecutive stable clk cycles before a button level is accepted.
REQ-002 clk  input  1  system clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 tick_1hz  input  1  single-cycle enable, 1 Hz; advances the time in RUN.
REQ-005 tick_2hz  input  1  single-cycle enable, 2 Hz; drives increments in ADJUST.
REQ-006 btn_pause  input  1  raw asynchronous pushbutton, active-high; start/pause.
REQ-007 btn_clear  input  1  raw asynchronous pushbutton, active-high; clear.
REQ-008 sw_adj  input  1  raw slide switch; 1 requests adjust mode.
REQ-009 sw_sel  input  1  raw slide switch; 0 selects minutes and 1 selects seconds for adjust.
REQ-010 minutes  output  8  binary minutes, 0-59; feeds the 7-segment display driver directly.
REQ-011 seconds  output  8  binary seconds, 0-59; feeds the 7-segment display driver directly.
REQ-012 running  output  1  high only while the state is RUN.

Function
REQ-013 Each raw input shall pass through a 2-flop synchronizer and then the debouncer; btn_pause and btn_clear shall additionally produce a 1-cycle rising-edge pulse (press_pause, press_clear).
REQ-014 Synchronizer plus debounce latency shall be 2 + DEBOUNCE_CYCLES clk cycles from a stable raw level to the debounced level, plus 1 cycle to the press pulse.
REQ-015 A raw input that toggles before DEBOUNCE_CYCLES stable cycles have elapsed shall restart the stability count and produce no level change.
REQ-016 The FSM shall have the states IDLE, RUN, PAUSE and ADJ; it shall reset to IDLE.
REQ-017 IDLE->RUN and PAUSE->RUN shall occur on press_pause; RUN->PAUSE shall occur on press_pause.
REQ-018 press_clear in any state shall zero minutes and seconds and enter IDLE on the next cycle.
REQ-019 press_clear shall take priority over press_pause in the same cycle.
REQ-020 IDLE or PAUSE shall go to ADJ while debounced sw_adj=1.
REQ-021 ADJ shall go to PAUSE when sw_adj=0.
REQ-022 sw_adj=1 during RUN shall be ignored until the state leaves RUN.
REQ-023 In RUN, tick_1hz shall increment seconds one cycle after the tick.
REQ-024 In RUN, seconds=59 with tick_1hz shall set seconds to 0 and increment minutes in the same cycle.
REQ-025 In RUN, 59:59 with tick_1hz shall wrap to 00:00 and stay in RUN.
REQ-026 In ADJ, tick_2hz shall increment only the field selected by sw_sel, 59->0 with no carry into the other field.
REQ-027 tick_1hz shall be ignored outside RUN; tick_2hz shall be ignored outside ADJ.
REQ-028 press_pause in ADJ shall be ignored.
REQ-029 A tick and press_pause in the same cycle in RUN shall apply the increment, then enter PAUSE.
REQ-030 minutes and seconds shall be driven directly from registers and shall never exceed 59.

Reset
REQ-031 Asserting rst_n low at any time, including mid-debounce or mid-increment, shall immediately force IDLE, minutes=0, seconds=0, running=0, synchronizer and debouncer state to 0, and press pulses to 0.
REQ-032 After rst_n deasserts, a button already held shall generate no press pulse until it is released and pressed again.

Configuration
REQ-033 Macro STOPWATCH_ADJUST_EN defined: the ADJ state, sw_adj, sw_sel and tick_2hz behave as in REQ-020, REQ-021, REQ-026 and REQ-027.
REQ-034 Macro STOPWATCH_ADJUST_EN undefined: the ADJ state and its debouncers are absent, sw_adj, sw_sel and tick_2hz are ignored, and the ports remain present.

Structure
REQ-035 A shared package shall hold the state enumeration (IDLE, RUN, PAUSE, ADJ), the constant MAX_FIELD=59 and the field width constant 8.
REQ-036 One sub-module, btn_debounce (synchronizer, stability counter, debounced level, rise pulse), shall be instantiated per raw input.
REQ-037 The FSM and counters shall reside in stopwatch_core.

Verification (DEBOUNCE_CYCLES=4 in benches)
REQ-038 Reset, then btn_pause held 10 cycles -> press pulse 7 cycles after the rise, state RUN, running=1.
REQ-039 RUN at 00:58, two tick_1hz pulses -> 00:59, then 01:00; at 59:59 one tick -> 00:00 with running=1.
REQ-040 btn_pause bouncing 1-0-1 with 2-cycle widths, then stable -> exactly one press pulse.
REQ-041 RUN at 03:07, tick_1hz and press_pause in the same cycle -> 03:08, then PAUSE; further ticks -> no change.
REQ-042 PAUSE, sw_adj=1, sw_sel=1, seconds=59, one tick_2hz -> 03:00 (no carry); sw_sel=0, one tick_2hz -> 04:00; sw_adj=0 -> PAUSE.
REQ-043 rst_n pulsed low mid-RUN at 12:34 -> 00:00 and IDLE asynchronously; press_clear and press_pause together in PAUSE -> IDLE at 00:00.
